nec_bus_responder: RTL and testbench
====================================

Name: nec_bus_responder

Overview:
- Bus-slave side of the external NEC V30-family CPU interface. The CPU is the initiator; this block is the responder.
- Latches the multiplexed address on ASTB and decodes read, write and interrupt-acknowledge cycles.
- Forwards each access to a single-request memory/IO port, drives read data back onto AD, and holds READY low until data is available.
- Sits in emu between the NEC_* pins and the core's RAM/IO fabric, clocked by clk_sys.

Parameters:
- TIMEOUT, 64, clk cycles to wait for mem_ack before forcing completion.
- SYNC_STAGES, 2, synchronizer depth on ASTB/RDn/WRn/INTAKn (minimum 2).

Ports:
- clk  in  1  system clock (clk_sys).
- reset  in  1  synchronous, active-high reset.
- nec_ad_in  in  20  raw AD19..AD0 from pins.
- nec_ad_out  out  16  data driven onto AD15..AD0.
- nec_ad_oe  out  1  tri-state enable for nec_ad_out.
- nec_ad_dir  out  1  level-shifter direction; 1 = FPGA->CPU.
- nec_ready  out  1  CPU READY.
- nec_astb / nec_rdn / nec_wrn / nec_intakn / nec_ion / nec_ubenn  in  1 each  raw CPU strobes.
- mem_addr  out  20  latched byte address.
- mem_be  out  2  byte enables: [0] = ~A0, [1] = ~UBEn.
- mem_io  out  1  1 = IO space (IOn low at latch).
- mem_rd / mem_wr  out  1  single-cycle request pulses.
- mem_wdata  out  16  write data.
- mem_rdata  in  16  read data, valid with mem_ack.
- mem_ack  in  1  request complete; must arrive at least 1 cycle after the request.
- int_vector  in  8  vector returned on the second INTA cycle.
- timeout_err  out  1  1-cycle pulse when a request times out.

Behaviour:
- Synchronize strobes through SYNC_STAGES flops; edges are detected on the synchronized values.
- Address capture: each cycle while raw nec_astb = 1, sample nec_ad_in, nec_ion and nec_ubenn into a shadow register.
- On synchronized ASTB falling edge: copy shadow to mem_addr/mem_be/mem_io, drive nec_ready = 0, enter ADDR.
- Reset (any state, mid-cycle included): state IDLE, nec_ready = 1, nec_ad_oe = 0, nec_ad_dir = 0, mem_rd = mem_wr = 0, timeout_err = 0, nec_ad_out = 0, INTA toggle = 0, no partial request is emitted.
- IDLE: wait for ASTB fall.
- ADDR:
  - sync INTAKn low -> INTA;
  - else sync RDn low -> RD_REQ;
  - else sync WRn low -> WR_REQ;
  - a new ASTB fall relatches the address (aborted cycle) and stays in ADDR.
- RD_REQ: mem_rd = 1 for exactly 1 cycle -> RD_WAIT.
- RD_WAIT:
  - on mem_ack, latch mem_rdata into nec_ad_out -> RD_DRIVE;
  - after TIMEOUT cycles with no ack, nec_ad_out = 16'hFFFF, pulse timeout_err -> RD_DRIVE.
- RD_DRIVE: nec_ad_oe = 1, nec_ad_dir = 1, nec_ready = 1. On sync RDn high, clear oe and dir in the same cycle -> IDLE.
- WR_REQ:
  - sample nec_ad_in[15:0] into mem_wdata (data is settled after the synchronizer delay);
  - mem_wr = 1 for 1 cycle -> WR_WAIT.
- WR_WAIT: on ack or TIMEOUT (pulse timeout_err on timeout) -> WR_DONE.
- WR_DONE: nec_ready = 1; on sync WRn high -> IDLE.
- INTA: no mem request is issued.
  - Toggle 0 (first INTA cycle): ready = 1, no drive.
  - Toggle 1: nec_ad_out = {8'h00, int_vector}, oe = 1, dir = 1, ready = 1.
  - Flip the toggle and -> IDLE on sync INTAKn high.
- Odd-byte access (A0 = 1, UBEn = 0): mem_be = 2'b10. mem_rdata is returned unmodified; the memory side places the byte on [15:8].
- Read latency: mem_rd asserts 1 cycle after the RDn edge is detected. nec_ready rises in the cycle after mem_ack.
- nec_ad_oe never asserts unless RDn or INTAKn is synchronized low. nec_ad_oe = 1 and a write state are mutually exclusive.
- Timeout counter clears on every entry to RD_WAIT/WR_WAIT. The count is a compare-equal to TIMEOUT-1, with width $clog2(TIMEOUT+1).

Decomposition:
- nec_bus_pkg: state enum (IDLE, ADDR, RD_REQ, RD_WAIT, RD_DRIVE, WR_REQ, WR_WAIT, WR_DONE, INTA) and byte-enable decode constants.
- One sub-module: nec_strobe_sync, a SYNC_STAGES synchronizer with falling/rising edge outputs, instanced per strobe.

Test Plan:
- Word read:
  - Stimulus: ASTB with AD = 20'h12340, IOn = 1, UBEn = 0, then RDn low; mem_ack after 3 cycles with rdata = 16'hBEEF.
  - Required: mem_addr = 20'h12340, mem_be = 2'b11, mem_io = 0, single mem_rd pulse.
  - Required: nec_ready low until the cycle after ack; AD driven with 16'hBEEF while RDn is low; oe drops when RDn rises.
- Odd-byte IO write:
  - Stimulus: AD = 20'h00081, IOn = 0, UBEn = 0, WRn low with data 16'h5A00.
  - Required: mem_io = 1, mem_be = 2'b10, mem_wdata = 16'h5A00, a single mem_wr pulse, oe never asserted.
- Timeout:
  - Stimulus: read with no mem_ack.
  - Required: after TIMEOUT cycles, timeout_err pulses once, AD = 16'hFFFF, ready = 1.
- INTA pair:
  - Stimulus: two ASTB+INTAKn cycles with int_vector = 8'h21.
  - Required: first cycle no drive and no mem request; second cycle AD = 16'h0021.
- Reset mid-read:
  - Stimulus: assert reset during RD_DRIVE.
  - Required: next cycle ready = 1, oe = 0, dir = 0, state IDLE; the next full read completes normally.
- Aborted cycle:
  - Stimulus: two ASTB pulses, 20'h00010 then 20'h00020, with no strobe between; then RDn.
  - Required: the request uses 20'h00020.

Source files
------------

// File: rtl/nec_bus_pkg.sv
// Shared types for the NEC V30 bus responder: FSM state encoding and byte-enable decode.
package nec_bus_pkg;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_ADDR,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_RD_DRIVE,
        ST_WR_REQ,
        ST_WR_WAIT,
        ST_WR_DONE,
        ST_INTA
    } nec_state_e;

    localparam logic [1:0] BE_NONE = 2'b00;
    localparam logic [1:0] BE_LOW  = 2'b01;
    localparam logic [1:0] BE_HIGH = 2'b10;
    localparam logic [1:0] BE_WORD = 2'b11;

    // A0 selects the low lane, UBEn (active low) enables the high lane.
    function automatic logic [1:0] be_decode(input logic a0, input logic ubenn);
        logic [1:0] be;
        case ({ubenn, a0})
            2'b00:   be = BE_WORD;
            2'b01:   be = BE_HIGH;
            2'b10:   be = BE_LOW;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/nec_strobe_sync.sv
// Multi-stage synchronizer for one raw CPU strobe, with edge pulses on the synchronized level.
module nec_strobe_sync #(
    parameter int   STAGES   = 2,
    parameter logic IDLE_LVL = 1'b1
) (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic q,
    output logic fall,
    output logic rise
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= {STAGES{IDLE_LVL}};
            prev_q <= IDLE_LVL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], din};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q    = sync_q[STAGES-1];
    assign fall = prev_q & ~q;
    assign rise = ~prev_q & q;

endmodule

// File: rtl/nec_bus_responder.sv
// Bus-slave side of the NEC V30 interface: latches the address on ASTB, forwards
// read/write cycles to a single-request memory/IO port and answers INTA cycles.
//
// state    | meaning
// IDLE     | waiting for ASTB to fall
// ADDR     | address latched, READY low, waiting for RDn/WRn/INTAKn
// RD_REQ   | one-cycle mem_rd pulse
// RD_WAIT  | waiting for mem_ack or timeout
// RD_DRIVE | read data on AD, READY high until RDn returns high
// WR_REQ   | one-cycle mem_wr pulse
// WR_WAIT  | waiting for mem_ack or timeout
// WR_DONE  | READY high until WRn returns high
// INTA     | interrupt acknowledge; second cycle of the pair drives the vector
module nec_bus_responder
    import nec_bus_pkg::*;
#(
    parameter int TIMEOUT     = 64,
    parameter int SYNC_STAGES = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [19:0] nec_ad_in,
    output logic [15:0] nec_ad_out,
    output logic        nec_ad_oe,
    output logic        nec_ad_dir,
    output logic        nec_ready,
    input  logic        nec_astb,
    input  logic        nec_rdn,
    input  logic        nec_wrn,
    input  logic        nec_intakn,
    input  logic        nec_ion,
    input  logic        nec_ubenn,
    output logic [19:0] mem_addr,
    output logic [1:0]  mem_be,
    output logic        mem_io,
    output logic        mem_rd,
    output logic        mem_wr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata,
    input  logic        mem_ack,
    input  logic [7:0]  int_vector,
    output logic        timeout_err
);

    localparam int               CNT_W    = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    logic astb_q, astb_fall, astb_rise;
    logic rdn_q, rdn_fall, rdn_rise;
    logic wrn_q, wrn_fall, wrn_rise;
    logic intakn_q, intakn_fall, intakn_rise;
    logic unused_edges;

    nec_strobe_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b0)) u_sync_astb (
        .clk(clk), .reset(reset), .din(nec_astb),
        .q(astb_q), .fall(astb_fall), .rise(astb_rise)
    );
    nec_strobe_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_rdn (
        .clk(clk), .reset(reset), .din(nec_rdn),
        .q(rdn_q), .fall(rdn_fall), .rise(rdn_rise)
    );
    nec_strobe_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_wrn (
        .clk(clk), .reset(reset), .din(nec_wrn),
        .q(wrn_q), .fall(wrn_fall), .rise(wrn_rise)
    );
    nec_strobe_sync #(.STAGES(SYNC_STAGES), .IDLE_LVL(1'b1)) u_sync_intakn (
        .clk(clk), .reset(reset), .din(nec_intakn),
        .q(intakn_q), .fall(intakn_fall), .rise(intakn_rise)
    );

    // The FSM works on levels; only the ASTB fall is needed as an event.
    assign unused_edges = ^{astb_q, astb_rise, rdn_fall, rdn_rise, wrn_fall, wrn_rise,
                            intakn_fall, intakn_rise};

    nec_state_e       state_q, state_d;
    logic [19:0]      shadow_addr;
    logic             shadow_ion;
    logic             shadow_ubenn;
    logic [CNT_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic             inta_toggle;
    logic             addr_open;

    assign tmo_hit   = (tmo_cnt == CNT_LAST);
    assign addr_open = (state_q == ST_IDLE) || (state_q == ST_ADDR);

    // Raw ASTB is used here on purpose: the address is only stable while ASTB is high.
    always_ff @(posedge clk) begin
        if (reset) begin
            shadow_addr  <= '0;
            shadow_ion   <= 1'b1;
            shadow_ubenn <= 1'b1;
        end else if (nec_astb) begin
            shadow_addr  <= nec_ad_in;
            shadow_ion   <= nec_ion;
            shadow_ubenn <= nec_ubenn;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        nec_ready   = 1'b1;
        nec_ad_oe   = 1'b0;
        timeout_err = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (astb_fall) state_d = ST_ADDR;
            end
            ST_ADDR: begin
                nec_ready = 1'b0;
                if (astb_fall)      state_d = ST_ADDR;
                else if (!intakn_q) state_d = ST_INTA;
                else if (!rdn_q)    state_d = ST_RD_REQ;
                else if (!wrn_q)    state_d = ST_WR_REQ;
            end
            ST_RD_REQ: begin
                nec_ready = 1'b0;
                mem_rd    = 1'b1;
                state_d   = ST_RD_WAIT;
            end
            ST_RD_WAIT: begin
                nec_ready   = 1'b0;
                timeout_err = tmo_hit & ~mem_ack;
                if (mem_ack || tmo_hit) state_d = ST_RD_DRIVE;
            end
            ST_RD_DRIVE: begin
                nec_ad_oe = ~rdn_q;
                if (rdn_q) state_d = ST_IDLE;
            end
            ST_WR_REQ: begin
                nec_ready = 1'b0;
                mem_wr    = 1'b1;
                state_d   = ST_WR_WAIT;
            end
            ST_WR_WAIT: begin
                nec_ready   = 1'b0;
                timeout_err = tmo_hit & ~mem_ack;
                if (mem_ack || tmo_hit) state_d = ST_WR_DONE;
            end
            ST_WR_DONE: begin
                if (wrn_q) state_d = ST_IDLE;
            end
            ST_INTA: begin
                nec_ad_oe = inta_toggle & ~intakn_q;
                if (intakn_q) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign nec_ad_dir = nec_ad_oe;

    always_ff @(posedge clk) begin
        if (reset) begin
            mem_addr    <= '0;
            mem_be      <= BE_NONE;
            mem_io      <= 1'b0;
            mem_wdata   <= '0;
            nec_ad_out  <= '0;
            tmo_cnt     <= '0;
            inta_toggle <= 1'b0;
        end else begin
            if (astb_fall && addr_open) begin
                mem_addr <= shadow_addr;
                mem_be   <= be_decode(shadow_addr[0], shadow_ubenn);
                mem_io   <= ~shadow_ion;
            end
            // Write data has been on AD since before WRn made it through the synchronizer.
            if (state_q == ST_ADDR && state_d == ST_WR_REQ) begin
                mem_wdata <= nec_ad_in[15:0];
            end
            if (state_q == ST_ADDR && state_d == ST_INTA && inta_toggle) begin
                nec_ad_out <= {8'h00, int_vector};
            end
            case (state_q)
                ST_RD_REQ, ST_WR_REQ: tmo_cnt <= '0;
                ST_RD_WAIT: begin
                    if (mem_ack)      nec_ad_out <= mem_rdata;
                    else if (tmo_hit) nec_ad_out <= 16'hFFFF;
                    else              tmo_cnt    <= tmo_cnt + 1'b1;
                end
                ST_WR_WAIT: begin
                    if (!mem_ack && !tmo_hit) tmo_cnt <= tmo_cnt + 1'b1;
                end
                ST_INTA: begin
                    if (intakn_q) inta_toggle <= ~inta_toggle;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_nec_bus_responder.sv
// Self-checking bench for nec_bus_responder: vector table of bus cycles plus corner-case sequences.
module tb_nec_bus_responder;

    localparam int TIMEOUT = 64;

    logic        clk = 1'b0;
    logic        reset;
    logic [19:0] nec_ad_in;
    logic [15:0] nec_ad_out;
    logic        nec_ad_oe, nec_ad_dir, nec_ready;
    logic        nec_astb, nec_rdn, nec_wrn, nec_intakn, nec_ion, nec_ubenn;
    logic [19:0] mem_addr;
    logic [1:0]  mem_be;
    logic        mem_io, mem_rd, mem_wr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = 16'h0000;
    logic        mem_ack = 1'b0;
    logic [7:0]  int_vector;
    logic        timeout_err;

    nec_bus_responder #(.TIMEOUT(TIMEOUT), .SYNC_STAGES(2)) dut (
        .clk(clk), .reset(reset),
        .nec_ad_in(nec_ad_in), .nec_ad_out(nec_ad_out), .nec_ad_oe(nec_ad_oe),
        .nec_ad_dir(nec_ad_dir), .nec_ready(nec_ready),
        .nec_astb(nec_astb), .nec_rdn(nec_rdn), .nec_wrn(nec_wrn),
        .nec_intakn(nec_intakn), .nec_ion(nec_ion), .nec_ubenn(nec_ubenn),
        .mem_addr(mem_addr), .mem_be(mem_be), .mem_io(mem_io),
        .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .int_vector(int_vector),
        .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [19:0] addr;
        logic [1:0]  be;
        logic        io;
        logic [15:0] wdata;
    } req_t;

    typedef struct {
        logic        wr;
        logic [19:0] ad;
        logic        ion;
        logic        ubenn;
        logic [15:0] wdata;
        logic [15:0] rdata;
        int          delay;
        logic [1:0]  exp_be;
        logic        exp_io;
    } vec_t;

    req_t        sb_q[$];
    logic [15:0] ad_q[$];
    vec_t        vecs[6];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int req_pulses = 0;
    int te_count = 0;
    int rd_cyc = 0;
    int ack_cyc = 0;
    int ack_delay = 1;
    bit ack_en = 1'b1;
    logic [15:0] rdata_val = 16'h0000;
    logic        oe_prev = 1'b0;
    logic [1:0]  rdn_d = 2'b11, wrn_d = 2'b11, intakn_d = 2'b11;

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        rdn_d    <= {rdn_d[0], nec_rdn};
        wrn_d    <= {wrn_d[0], nec_wrn};
        intakn_d <= {intakn_d[0], nec_intakn};
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Memory model: acknowledges each request ack_delay cycles after it is seen.
    always begin
        @(negedge clk);
        if ((mem_rd || mem_wr) && ack_en) begin
            repeat (ack_delay) @(negedge clk);
            mem_ack   = 1'b1;
            mem_rdata = rdata_val;
            ack_cyc   = cyc;
            @(negedge clk);
            mem_ack = 1'b0;
        end
    end

    // Monitor: request scoreboard, AD drive scoreboard and output-enable invariants.
    always @(negedge clk) begin
        req_t e;
        if (timeout_err) te_count++;
        if (mem_rd || mem_wr) begin
            req_pulses++;
            if (mem_rd) rd_cyc = cyc;
            checks++;
            if (sb_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_req rd=%0b wr=%0b addr=%h", mem_rd, mem_wr, mem_addr);
            end else begin
                e = sb_q.pop_front();
                if (!((mem_wr == e.wr) && (mem_rd == !e.wr) && (mem_addr == e.addr) &&
                      (mem_be == e.be) && (mem_io == e.io) && (!e.wr || mem_wdata == e.wdata))) begin
                    failures++;
                    $display("FAIL req got wr=%0b addr=%h be=%b io=%0b wdata=%h exp wr=%0b addr=%h be=%b io=%0b wdata=%h",
                             mem_wr, mem_addr, mem_be, mem_io, mem_wdata, e.wr, e.addr, e.be, e.io, e.wdata);
                end
            end
        end
        if (nec_ad_oe && !oe_prev) begin
            checks++;
            if (ad_q.size() == 0) begin
                failures++;
                $display("FAIL unexpected_drive ad=%h", nec_ad_out);
            end else if (nec_ad_out !== ad_q[0]) begin
                failures++;
                $display("FAIL drive_data got=%h exp=%h", nec_ad_out, ad_q[0]);
                void'(ad_q.pop_front());
            end else begin
                void'(ad_q.pop_front());
            end
        end
        if (nec_ad_oe) begin
            checks++;
            if (!(rdn_d[1] == 1'b0 || intakn_d[1] == 1'b0) || wrn_d[1] == 1'b0 || nec_ad_dir !== 1'b1) begin
                failures++;
                $display("FAIL oe_invariant oe=%0b dir=%0b rdn_s=%0b intakn_s=%0b wrn_s=%0b",
                         nec_ad_oe, nec_ad_dir, rdn_d[1], intakn_d[1], wrn_d[1]);
            end
        end
        oe_prev = nec_ad_oe;
    end

    // which: 0 = nec_ready, 1 = nec_ad_oe, 2 = timeout_err
    task automatic wait_for(input int which, input logic val, output int at, output bit ok);
        logic s;
        ok = 1'b0;
        at = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            case (which)
                0:       s = nec_ready;
                1:       s = nec_ad_oe;
                default: s = timeout_err;
            endcase
            if (s == val) begin
                ok = 1'b1;
                at = cyc;
                return;
            end
        end
    endtask

    task automatic start_addr(input logic [19:0] a, input logic ion, input logic ubenn);
        int at;
        bit ok;
        @(negedge clk);
        nec_ad_in = a;
        nec_ion   = ion;
        nec_ubenn = ubenn;
        nec_astb  = 1'b1;
        repeat (2) @(negedge clk);
        nec_astb  = 1'b0;
        nec_ad_in = '0;
        wait_for(0, 1'b0, at, ok);
        chk("astb_ready_low", 32'(ok), 32'd1);
    endtask

    task automatic push_read(input logic [19:0] a, input logic [1:0] be, input logic io,
                             input logic [15:0] rdata);
        req_t e;
        e.wr = 1'b0; e.addr = a; e.be = be; e.io = io; e.wdata = 16'h0000;
        sb_q.push_back(e);
        ad_q.push_back(rdata);
    endtask

    task automatic bus_cycle(input vec_t v);
        req_t e;
        int   at, p0;
        bit   ok;
        if (v.wr) begin
            e.wr = 1'b1; e.addr = v.ad; e.be = v.exp_be; e.io = v.exp_io; e.wdata = v.wdata;
            sb_q.push_back(e);
        end else begin
            push_read(v.ad, v.exp_be, v.exp_io, v.rdata);
        end
        ack_en    = 1'b1;
        ack_delay = v.delay;
        rdata_val = v.rdata;
        start_addr(v.ad, v.ion, v.ubenn);
        p0 = req_pulses;
        @(negedge clk);
        if (v.wr) begin
            nec_ad_in = {4'h0, v.wdata};
            nec_wrn   = 1'b0;
        end else begin
            nec_rdn = 1'b0;
        end
        wait_for(0, 1'b1, at, ok);
        chk("ready_rise", 32'(ok), 32'd1);
        chk("ready_after_ack", 32'(at), 32'(ack_cyc + 1));
        if (!v.wr) begin
            chk("rd_oe", 32'(nec_ad_oe), 32'd1);
            chk("rd_dir", 32'(nec_ad_dir), 32'd1);
            chk("rd_data", 32'(nec_ad_out), 32'(v.rdata));
            nec_rdn = 1'b1;
            wait_for(1, 1'b0, at, ok);
            chk("oe_release", 32'(ok), 32'd1);
            chk("dir_release", 32'(nec_ad_dir), 32'd0);
        end else begin
            chk("wr_oe", 32'(nec_ad_oe), 32'd0);
            nec_wrn   = 1'b1;
            nec_ad_in = '0;
        end
        repeat (4) @(negedge clk);
        chk("req_count", 32'(req_pulses - p0), 32'd1);
        chk("ready_idle", 32'(nec_ready), 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog cyc=%0d", cyc);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int  at, tat, p0, t0;
        bit  ok;

        vecs[0] = '{1'b0, 20'h12340, 1'b1, 1'b0, 16'h0000, 16'hBEEF, 3, 2'b11, 1'b0};
        vecs[1] = '{1'b1, 20'h00081, 1'b0, 1'b0, 16'h5A00, 16'h0000, 2, 2'b10, 1'b1};
        vecs[2] = '{1'b0, 20'h00100, 1'b1, 1'b1, 16'h0000, 16'h00C3, 1, 2'b01, 1'b0};
        vecs[3] = '{1'b1, 20'h0ABCE, 1'b1, 1'b0, 16'h1234, 16'h0000, 5, 2'b11, 1'b0};
        vecs[4] = '{1'b0, 20'h00301, 1'b0, 1'b0, 16'h0000, 16'h7700, 2, 2'b10, 1'b1};
        vecs[5] = '{1'b1, 20'hFFFFE, 1'b1, 1'b1, 16'h00AA, 16'h0000, 1, 2'b01, 1'b0};

        reset      = 1'b1;
        nec_ad_in  = '0;
        nec_astb   = 1'b0;
        nec_rdn    = 1'b1;
        nec_wrn    = 1'b1;
        nec_intakn = 1'b1;
        nec_ion    = 1'b1;
        nec_ubenn  = 1'b1;
        int_vector = 8'h21;
        repeat (4) @(negedge clk);
        reset = 1'b0;
        chk("rst_ready", 32'(nec_ready), 32'd1);
        chk("rst_oe", 32'(nec_ad_oe), 32'd0);
        chk("rst_dir", 32'(nec_ad_dir), 32'd0);
        chk("rst_req", 32'({mem_rd, mem_wr}), 32'd0);
        chk("rst_te", 32'(timeout_err), 32'd0);
        chk("rst_ad_out", 32'(nec_ad_out), 32'd0);

        for (int i = 0; i < 6; i++) bus_cycle(vecs[i]);

        // Read with no acknowledge: forced completion after TIMEOUT cycles.
        ack_en = 1'b0;
        push_read(20'h04000, 2'b11, 1'b0, 16'hFFFF);
        t0 = te_count;
        start_addr(20'h04000, 1'b1, 1'b0);
        @(negedge clk);
        nec_rdn = 1'b0;
        wait_for(2, 1'b1, tat, ok);
        chk("te_seen", 32'(ok), 32'd1);
        chk("te_latency", 32'(tat - rd_cyc), 32'(TIMEOUT));
        chk("te_ready_low", 32'(nec_ready), 32'd0);
        wait_for(0, 1'b1, at, ok);
        chk("te_ready", 32'(at), 32'(tat + 1));
        chk("te_data", 32'(nec_ad_out), 32'hFFFF);
        chk("te_oe", 32'(nec_ad_oe), 32'd1);
        nec_rdn = 1'b1;
        wait_for(1, 1'b0, at, ok);
        repeat (4) @(negedge clk);
        chk("te_pulses", 32'(te_count - t0), 32'd1);
        ack_en = 1'b1;

        // INTA pair: first cycle is silent, second drives the vector.
        p0 = req_pulses;
        start_addr(20'h00000, 1'b1, 1'b1);
        @(negedge clk);
        nec_intakn = 1'b0;
        wait_for(0, 1'b1, at, ok);
        chk("inta1_ready", 32'(ok), 32'd1);
        chk("inta1_oe", 32'(nec_ad_oe), 32'd0);
        repeat (3) @(negedge clk);
        chk("inta1_oe_hold", 32'(nec_ad_oe), 32'd0);
        nec_intakn = 1'b1;
        repeat (4) @(negedge clk);
        ad_q.push_back(16'h0021);
        start_addr(20'h00000, 1'b1, 1'b1);
        @(negedge clk);
        nec_intakn = 1'b0;
        wait_for(0, 1'b1, at, ok);
        chk("inta2_ready", 32'(ok), 32'd1);
        chk("inta2_oe", 32'(nec_ad_oe), 32'd1);
        chk("inta2_data", 32'(nec_ad_out), 32'h0021);
        nec_intakn = 1'b1;
        wait_for(1, 1'b0, at, ok);
        repeat (4) @(negedge clk);
        chk("inta_no_req", 32'(req_pulses - p0), 32'd0);

        // Reset while the read data is being driven.
        push_read(20'h00200, 2'b11, 1'b0, 16'h1357);
        ack_delay = 2;
        rdata_val = 16'h1357;
        start_addr(20'h00200, 1'b1, 1'b0);
        @(negedge clk);
        nec_rdn = 1'b0;
        wait_for(0, 1'b1, at, ok);
        chk("mid_rd_oe", 32'(nec_ad_oe), 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("mid_rst_ready", 32'(nec_ready), 32'd1);
        chk("mid_rst_oe", 32'(nec_ad_oe), 32'd0);
        chk("mid_rst_dir", 32'(nec_ad_dir), 32'd0);
        chk("mid_rst_ad_out", 32'(nec_ad_out), 32'd0);
        @(negedge clk);
        chk("mid_rst_idle", 32'({nec_ad_oe, nec_ready, mem_rd}), 32'b010);
        nec_rdn = 1'b1;
        repeat (4) @(negedge clk);
        bus_cycle(vecs[2]);

        // Aborted cycle: second ASTB relatches before any strobe.
        push_read(20'h00020, 2'b11, 1'b0, 16'h4242);
        ack_delay = 2;
        rdata_val = 16'h4242;
        start_addr(20'h00010, 1'b1, 1'b0);
        start_addr(20'h00020, 1'b1, 1'b0);
        repeat (4) @(negedge clk);
        nec_rdn = 1'b0;
        wait_for(0, 1'b1, at, ok);
        chk("abort_ready", 32'(ok), 32'd1);
        chk("abort_data", 32'(nec_ad_out), 32'h4242);
        chk("abort_addr", 32'(mem_addr), 32'h00020);
        nec_rdn = 1'b1;
        wait_for(1, 1'b0, at, ok);
        repeat (4) @(negedge clk);

        chk("sb_empty", 32'(sb_q.size()), 32'd0);
        chk("ad_q_empty", 32'(ad_q.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
